// File: rtl/axil_pkg.sv
// Shared types and defaults for the dual-master AXI4-Lite BRAM system.
// Response codes, the transaction FSM encoding and the BRAM window live here.
package axil_pkg;

   typedef logic [1:0] resp_t;

   localparam resp_t OKAY   = 2'b00;
   localparam resp_t DECERR = 2'b11;

   localparam logic [31:0] BASE_ADDR_DEF = 32'h4000_0000;
   localparam int          MEM_BYTES_DEF = 16384;

   typedef enum logic [2:0] {
      IDLE,
      WACC,
      WRSP,
      RACC,
      RWAIT,
      RRSP
   } state_t;

endpackage

// File: rtl/bram_sp.sv
// Single-port block RAM with per-byte write enables and a registered read port.
// Contents are never reset; a write cycle does not update the read register.
module bram_sp #(
   parameter int DEPTH  = 4096,
   parameter int DATA_W = 32,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                en,
   input  logic [DATA_W/8-1:0] we,
   input  logic [IDX_W-1:0]    addr,
   input  logic [DATA_W-1:0]   wdata,
   output logic [DATA_W-1:0]   rdata
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         for (int b = 0; b < DATA_W/8; b++) begin
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
         if (we == '0) rdata_q <= mem[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/axil_dual_master_bram.sv
// Two AXI4-Lite masters sharing one BRAM slave through a round-robin arbiter.
// Only one transaction is in flight at a time; losers are held off with ready low.
module axil_dual_master_bram
   import axil_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_ADDR_DEF),
   parameter int                MEM_BYTES = MEM_BYTES_DEF
) (
   input  logic                clk_100MHz,
   input  logic                reset_rtl_0,
   input  logic [ADDR_W-1:0]   s0_awaddr,
   input  logic                s0_awvalid,
   output logic                s0_awready,
   input  logic [DATA_W-1:0]   s0_wdata,
   input  logic [DATA_W/8-1:0] s0_wstrb,
   input  logic                s0_wvalid,
   output logic                s0_wready,
   output logic [1:0]          s0_bresp,
   output logic                s0_bvalid,
   input  logic                s0_bready,
   input  logic [ADDR_W-1:0]   s0_araddr,
   input  logic                s0_arvalid,
   output logic                s0_arready,
   output logic [DATA_W-1:0]   s0_rdata,
   output logic [1:0]          s0_rresp,
   output logic                s0_rvalid,
   input  logic                s0_rready,
   input  logic [ADDR_W-1:0]   s1_awaddr,
   input  logic                s1_awvalid,
   output logic                s1_awready,
   input  logic [DATA_W-1:0]   s1_wdata,
   input  logic [DATA_W/8-1:0] s1_wstrb,
   input  logic                s1_wvalid,
   output logic                s1_wready,
   output logic [1:0]          s1_bresp,
   output logic                s1_bvalid,
   input  logic                s1_bready,
   input  logic [ADDR_W-1:0]   s1_araddr,
   input  logic                s1_arvalid,
   output logic                s1_arready,
   output logic [DATA_W-1:0]   s1_rdata,
   output logic [1:0]          s1_rresp,
   output logic                s1_rvalid,
   input  logic                s1_rready
);

   localparam int STRB_W = DATA_W / 8;
   localparam int DEPTH  = MEM_BYTES / STRB_W;
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int LSB    = $clog2(STRB_W);

   function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
      return (a >= BASE_ADDR) && ((a - BASE_ADDR) < ADDR_W'(MEM_BYTES));
   endfunction

   logic [1:0][ADDR_W-1:0] awaddr_a, araddr_a;
   logic [1:0][DATA_W-1:0] wdata_a;
   logic [1:0][STRB_W-1:0] wstrb_a;
   logic [1:0]             wr_req, rd_req, req, bready_a, rready_a;

   assign awaddr_a = {s1_awaddr, s0_awaddr};
   assign araddr_a = {s1_araddr, s0_araddr};
   assign wdata_a  = {s1_wdata, s0_wdata};
   assign wstrb_a  = {s1_wstrb, s0_wstrb};
   assign wr_req   = {s1_awvalid & s1_wvalid, s0_awvalid & s0_wvalid};
   assign rd_req   = {s1_arvalid, s0_arvalid};
   assign req      = wr_req | rd_req;
   assign bready_a = {s1_bready, s0_bready};
   assign rready_a = {s1_rready, s0_rready};

   state_t            state_q, state_d;
   logic              owner_q, owner_d, last_q, last_d, win;
   logic [1:0]        awready_q, awready_d, arready_q, arready_d;
   logic [1:0]        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
   resp_t             resp_q, resp_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rhit_q, rhit_d;

   logic              wr_hit, rd_hit, mem_en;
   logic [STRB_W-1:0] mem_we;
   logic [IDX_W-1:0]  mem_addr;
   logic [DATA_W-1:0] mem_rdata;

   assign wr_hit   = addr_hit(awaddr_a[owner_q]);
   assign rd_hit   = addr_hit(araddr_a[owner_q]);
   assign mem_en   = ((state_q == WACC) && wr_hit) || ((state_q == RACC) && rd_hit);
   assign mem_we   = ((state_q == WACC) && wr_hit) ? wstrb_a[owner_q] : '0;
   assign mem_addr = (state_q == WACC) ? awaddr_a[owner_q][LSB +: IDX_W]
                                       : araddr_a[owner_q][LSB +: IDX_W];

   // Grant goes to the master that was not served last, if it is asking.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      awready_d = '0;
      arready_d = '0;
      bvalid_d  = bvalid_q;
      rvalid_d  = rvalid_q;
      resp_d    = resp_q;
      rdata_d   = rdata_q;
      rhit_d    = rhit_q;
      win       = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               win     = req[~last_q] ? ~last_q : last_q;
               owner_d = win;
               last_d  = win;
               if (wr_req[win]) begin
                  state_d        = WACC;
                  awready_d[win] = 1'b1;
               end else begin
                  state_d        = RACC;
                  arready_d[win] = 1'b1;
               end
            end
         end
         WACC: begin
            state_d           = WRSP;
            bvalid_d[owner_q] = 1'b1;
            resp_d            = wr_hit ? OKAY : DECERR;
         end
         WRSP: begin
            if (bready_a[owner_q]) begin
               bvalid_d = '0;
               state_d  = IDLE;
            end
         end
         RACC: begin
            state_d = RWAIT;
            rhit_d  = rd_hit;
         end
         RWAIT: begin
            state_d           = RRSP;
            rvalid_d[owner_q] = 1'b1;
            resp_d            = rhit_q ? OKAY : DECERR;
            rdata_d           = rhit_q ? mem_rdata : '0;
         end
         RRSP: begin
            if (rready_a[owner_q]) begin
               rvalid_d = '0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // last_q starts at S1 so that S0 wins the first contest.
   always_ff @(posedge clk_100MHz or posedge reset_rtl_0) begin
      if (reset_rtl_0) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         awready_q <= '0;
         arready_q <= '0;
         bvalid_q  <= '0;
         rvalid_q  <= '0;
         resp_q    <= OKAY;
         rdata_q   <= '0;
         rhit_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         awready_q <= awready_d;
         arready_q <= arready_d;
         bvalid_q  <= bvalid_d;
         rvalid_q  <= rvalid_d;
         resp_q    <= resp_d;
         rdata_q   <= rdata_d;
         rhit_q    <= rhit_d;
      end
   end

   bram_sp #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_bram (
      .clk   (clk_100MHz),
      .en    (mem_en),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (wdata_a[owner_q]),
      .rdata (mem_rdata)
   );

   assign s0_awready = awready_q[0];
   assign s0_wready  = awready_q[0];
   assign s0_bvalid  = bvalid_q[0];
   assign s0_bresp   = bvalid_q[0] ? resp_q : OKAY;
   assign s0_arready = arready_q[0];
   assign s0_rvalid  = rvalid_q[0];
   assign s0_rresp   = rvalid_q[0] ? resp_q : OKAY;
   assign s0_rdata   = rvalid_q[0] ? rdata_q : '0;

   assign s1_awready = awready_q[1];
   assign s1_wready  = awready_q[1];
   assign s1_bvalid  = bvalid_q[1];
   assign s1_bresp   = bvalid_q[1] ? resp_q : OKAY;
   assign s1_arready = arready_q[1];
   assign s1_rvalid  = rvalid_q[1];
   assign s1_rresp   = rvalid_q[1] ? resp_q : OKAY;
   assign s1_rdata   = rvalid_q[1] ? rdata_q : '0;

endmodule

// File: tb/tb_axil_dual_master_bram.sv
// Self-checking bench for axil_dual_master_bram: directed scenarios plus random
// traffic, checked against a word-addressed memory model of the BRAM window.
module tb_axil_dual_master_bram;

   localparam int          BUDGET = 200;
   localparam logic [31:0] BASE   = 32'h4000_0000;
   localparam logic [31:0] LIMIT  = 32'h4000_4000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0][31:0] awaddr, wdata, araddr;
   logic [1:0][3:0]  wstrb;
   logic [1:0]       awvalid, wvalid, bready, arvalid, rready;

   logic        s0_awready, s0_wready, s0_bvalid, s0_arready, s0_rvalid;
   logic        s1_awready, s1_wready, s1_bvalid, s1_arready, s1_rvalid;
   logic [1:0]  s0_bresp, s0_rresp, s1_bresp, s1_rresp;
   logic [31:0] s0_rdata, s1_rdata;

   wire [1:0]       awready = {s1_awready, s0_awready};
   wire [1:0]       wready  = {s1_wready, s0_wready};
   wire [1:0]       bvalid  = {s1_bvalid, s0_bvalid};
   wire [1:0]       arready = {s1_arready, s0_arready};
   wire [1:0]       rvalid  = {s1_rvalid, s0_rvalid};
   wire [1:0][1:0]  bresp   = {s1_bresp, s0_bresp};
   wire [1:0][1:0]  rresp   = {s1_rresp, s0_rresp};
   wire [1:0][31:0] rdata   = {s1_rdata, s0_rdata};

   axil_dual_master_bram dut (
      .clk_100MHz (clk),        .reset_rtl_0 (rst),
      .s0_awaddr  (awaddr[0]),  .s0_awvalid  (awvalid[0]), .s0_awready (s0_awready),
      .s0_wdata   (wdata[0]),   .s0_wstrb    (wstrb[0]),   .s0_wvalid  (wvalid[0]),
      .s0_wready  (s0_wready),  .s0_bresp    (s0_bresp),   .s0_bvalid  (s0_bvalid),
      .s0_bready  (bready[0]),  .s0_araddr   (araddr[0]),  .s0_arvalid (arvalid[0]),
      .s0_arready (s0_arready), .s0_rdata    (s0_rdata),   .s0_rresp   (s0_rresp),
      .s0_rvalid  (s0_rvalid),  .s0_rready   (rready[0]),
      .s1_awaddr  (awaddr[1]),  .s1_awvalid  (awvalid[1]), .s1_awready (s1_awready),
      .s1_wdata   (wdata[1]),   .s1_wstrb    (wstrb[1]),   .s1_wvalid  (wvalid[1]),
      .s1_wready  (s1_wready),  .s1_bresp    (s1_bresp),   .s1_bvalid  (s1_bvalid),
      .s1_bready  (bready[1]),  .s1_araddr   (araddr[1]),  .s1_arvalid (arvalid[1]),
      .s1_arready (s1_arready), .s1_rdata    (s1_rdata),   .s1_rresp   (s1_rresp),
      .s1_rvalid  (s1_rvalid),  .s1_rready   (rready[1])
   );

   // ---------------- scoreboard ----------------
   int          checks = 0;
   int          errors = 0;
   logic [31:0] model [int];
   int          last_lat [2];
   int          wr_done [2];
   logic [31:0] last_rdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_hit(input logic [31:0] a);
      return (a >= BASE) && (a < LIMIT);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      if (!exp_hit(a)) return 32'h0;
      return model.exists(widx(a)) ? model[widx(a)] : 32'h0;
   endfunction

   task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] w;
      if (!exp_hit(a)) return;
      w = model_rd(a);
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      model[widx(a)] = w;
   endtask

   // ---------------- driver tasks ----------------
   // Called on a falling edge; returns on a falling edge with the FSM back in IDLE.
   task automatic wr_chk(input int m, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int max_lat);
      int cyc;
      awaddr[m] = a; wdata[m] = d; wstrb[m] = s;
      awvalid[m] = 1'b1; wvalid[m] = 1'b1;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!awready[m] && cyc < BUDGET);
      check($sformatf("s%0d_wready@%h", m, a), 32'(wready[m]), 32'd1);
      @(posedge clk); #1;
      awvalid[m] = 1'b0; wvalid[m] = 1'b0;
      do begin @(negedge clk); cyc++; end while (!bvalid[m] && cyc < BUDGET);
      check($sformatf("s%0d_wr_timeout@%h", m, a), 32'(cyc < BUDGET), 32'd1);
      check($sformatf("s%0d_bresp@%h", m, a), 32'(bresp[m]), exp_hit(a) ? 32'd0 : 32'd3);
      check($sformatf("s%0d_no_cross_bvalid", m), 32'(bvalid[1-m]), 32'd0);
      check($sformatf("s%0d_wr_lat_le_%0d", m, max_lat), 32'(cyc <= max_lat), 32'd1);
      model_wr(a, d, s);
      last_lat[m] = cyc;
      if (bvalid[m]) wr_done[m]++;
      @(posedge clk); #1;
      @(negedge clk);
   endtask

   task automatic rd_chk(input int m, input logic [31:0] a, input int max_lat);
      int cyc;
      araddr[m] = a; arvalid[m] = 1'b1;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!arready[m] && cyc < BUDGET);
      @(posedge clk); #1;
      arvalid[m] = 1'b0;
      do begin @(negedge clk); cyc++; end while (!rvalid[m] && cyc < BUDGET);
      check($sformatf("s%0d_rd_timeout@%h", m, a), 32'(cyc < BUDGET), 32'd1);
      check($sformatf("s%0d_rresp@%h", m, a), 32'(rresp[m]), exp_hit(a) ? 32'd0 : 32'd3);
      check($sformatf("s%0d_rdata@%h", m, a), rdata[m], model_rd(a));
      check($sformatf("s%0d_no_cross_rvalid", m), 32'(rvalid[1-m]), 32'd0);
      check($sformatf("s%0d_rd_lat_le_%0d", m, max_lat), 32'(cyc <= max_lat), 32'd1);
      last_lat[m] = cyc;
      last_rdata  = rdata[m];
      @(posedge clk); #1;
      @(negedge clk);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ready"}, {26'b0, awready, wready, arready}, 32'd0);
      check({tag, "_valid"}, {28'b0, bvalid, rvalid}, 32'd0);
      check({tag, "_resp"}, {24'b0, bresp, rresp}, 32'd0);
      check({tag, "_rdata"}, rdata[0] | rdata[1], 32'd0);
   endtask

   // ---------------- directed + random sequence ----------------
   longint      t0, t1;
   logic [31:0] ra, rd_a;
   int          rm, sel;

   initial begin
      awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
      awvalid = '0; wvalid = '0; arvalid = '0;
      bready = 2'b11; rready = 2'b11;
      wr_done[0] = 0; wr_done[1] = 0;

      // Reset held for 20 cycles.
      rst = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // Simultaneous first request: S0 must be served first.
      fork
         begin wr_chk(0, 32'h4000_0004, 32'hCAFE_0001, 4'hF, 2); t0 = $time; end
         begin wr_chk(1, 32'h4000_0100, 32'h1234_5678, 4'hF, 8); t1 = $time; end
      join
      check("first_winner_s0", 32'(t0 < t1), 32'd1);
      check("s0_first_wr_lat", 32'(last_lat[0]), 32'd2);
      rd_chk(0, 32'h4000_0004, 3);
      check("s0_rd_lat", 32'(last_lat[0]), 32'd3);
      check("s0_readback_literal", last_rdata, 32'hCAFE_0001);
      rd_chk(1, 32'h4000_0100, 3);

      // Flood: attacker streams 64 writes while the victim issues 15.
      wr_done[0] = 0; wr_done[1] = 0;
      fork
         for (int i = 0; i < 64; i++)
            wr_chk(1, 32'h4000_2000 + 32'(4*i), 32'hBAD0_0000 | 32'(i), 4'hF, BUDGET);
         for (int k = 0; k < 15; k++)
            wr_chk(0, 32'h4000_0000 + 32'(4*k), 32'hCAFE_0000 | 32'(k), 4'hF, 8);
      join
      check("flood_s1_done", 32'(wr_done[1]), 32'd64);
      check("flood_s0_done", 32'(wr_done[0]), 32'd15);
      for (int i = 0; i < 64; i++) rd_chk(i % 2, 32'h4000_2000 + 32'(4*i), 3);
      for (int k = 0; k < 15; k++) rd_chk(0, 32'h4000_0000 + 32'(4*k), 3);

      // Byte strobes.
      wr_chk(0, 32'h4000_0020, 32'hFFFF_FFFF, 4'hF, 2);
      wr_chk(0, 32'h4000_0020, 32'h1122_3344, 4'b0101, 2);
      rd_chk(1, 32'h4000_0020, 3);
      check("strobe_literal", last_rdata, 32'hFF22_FF44);
      wr_chk(1, 32'h4000_0020, 32'h0000_0000, 4'b0000, 2);
      rd_chk(0, 32'h4000_0020, 3);

      // Decode boundaries.
      wr_chk(0, 32'h4000_0000, 32'hA5A5_0000, 4'hF, 2);
      wr_chk(1, 32'h4000_4000, 32'hDEAD_BEEF, 4'hF, 2);
      rd_chk(1, 32'h4000_4000, 3);
      check("decerr_rdata_literal", last_rdata, 32'h0);
      rd_chk(0, 32'h4000_0000, 3);
      check("decerr_no_alias_literal", last_rdata, 32'hA5A5_0000);
      wr_chk(0, 32'h3FFF_FFFC, 32'h0BAD_0BAD, 4'hF, 2);
      rd_chk(0, 32'h3FFF_FFFC, 3);
      wr_chk(1, 32'h4000_3FFC, 32'h7777_8888, 4'hF, 2);
      rd_chk(0, 32'h4000_3FFE, 3);

      // Random sequential traffic over a pre-written pool plus miss addresses.
      for (int j = 0; j < 8; j++) wr_chk(j % 2, 32'h4000_1000 + 32'(4*j), $urandom, 4'hF, 2);
      for (int n = 0; n < 40; n++) begin
         rm  = int'($urandom_range(0, 1));
         sel = int'($urandom_range(0, 9));
         if (sel < 8)       ra = 32'h4000_1000 + 32'(4*sel) + 32'($urandom_range(0, 3));
         else if (sel == 8) ra = 32'h4000_4000 + 32'(4*$urandom_range(0, 15));
         else               ra = 32'h3FFF_FFF0 + 32'(4*$urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) wr_chk(rm, ra, $urandom, 4'($urandom_range(0, 15)), 2);
         else                            rd_chk(rm, ra, 3);
      end

      // Reset while a write response is pending.
      rd_a = 32'h4000_0040;
      bready[0] = 1'b0;
      awaddr[0] = rd_a; wdata[0] = 32'h5A5A_1234; wstrb[0] = 4'hF;
      awvalid[0] = 1'b1; wvalid[0] = 1'b1;
      for (int c = 0; c < BUDGET && !awready[0]; c++) @(negedge clk);
      @(posedge clk); #1;
      awvalid[0] = 1'b0; wvalid[0] = 1'b0;
      for (int c = 0; c < BUDGET && !bvalid[0]; c++) @(negedge clk);
      check("pre_reset_bvalid", 32'(bvalid[0]), 32'd1);
      model_wr(rd_a, 32'h5A5A_1234, 4'hF);
      rst = 1'b1;
      #1;
      check("mid_reset_bvalid_drop", 32'(bvalid[0]), 32'd0);
      check_idle_outputs("mid_reset");
      @(negedge clk);
      bready[0] = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      rd_chk(0, rd_a, 3);
      check("post_reset_data_literal", last_rdata, 32'h5A5A_1234);
      wr_chk(0, 32'h4000_0044, 32'h0000_00AA, 4'hF, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
